float_add_pipe: RTL and testbench

Parametrised, pipelined successor to the 8-bit combinational unsigned mini-float adder. It adds two unsigned floats of the form {exponent[EW], mantissa[MW]}, where value = mantissa × 2^exponent and there is no hidden bit. The block normalises on mantissa carry-out and saturates on exponent overflow. It sits in the datapath between operand producers and consumers, using a valid/ready handshake with three register stages.

---
 rtl/float_add_pipe_if.sv | 25 ++
 rtl/float_add_pipe.sv | 172 +++++++++++++++++
 tb/tb_float_add_pipe.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/float_add_pipe_if.sv
// Valid/ready operand and result bundle for float_add_pipe.
// The master drives operands and consumes results; the slave is the adder.
interface float_add_pipe_if #(
   parameter int unsigned EW = 3,
   parameter int unsigned MW = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [EW+MW-1:0]  a_in;
   logic [EW+MW-1:0]  b_in;
   logic              out_valid;
   logic              out_ready;
   logic [EW+MW-1:0]  result;
   logic              sat;

   modport master (
      output in_valid, a_in, b_in, out_ready,
      input  in_ready, out_valid, result, sat
   );

   modport slave (
      input  in_valid, a_in, b_in, out_ready,
      output in_ready, out_valid, result, sat
   );
endinterface

// File: rtl/float_add_pipe.sv
// Three-stage pipelined adder for unsigned {exp, mant} floats (no hidden bit), with carry
// normalisation and exponent saturation. Define FLOAT_ADD_ROUND_EN for round-half-up in stage 3.
module float_add_pipe #(
   parameter int unsigned EW = 3,
   parameter int unsigned MW = 5
) (
   input logic             clk,
   input logic             rst_n,
   float_add_pipe_if.slave bus
);
   localparam int unsigned W        = EW + MW;
   localparam int unsigned TW       = MW + 2;
   localparam int unsigned MaxShift = MW + 1;

   localparam logic [EW:0]   ExpOne   = {{EW{1'b0}}, 1'b1};
   localparam logic [EW:0]   ExpMax   = {1'b0, {EW{1'b1}}};
   localparam logic [MW-1:0] MantHalf = {1'b1, {(MW-1){1'b0}}};

   // All stages move in lockstep; the whole pipe freezes when the output is blocked.
   logic adv;
   logic out_valid_q;

   assign adv           = !out_valid_q || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = out_valid_q;

   // ---------------- Stage 1: order operands ----------------
   logic [EW-1:0] a_exp, b_exp, l_exp, s_exp, shift;
   logic [MW-1:0] a_mant, b_mant, l_mant, s_mant;
   logic          a_is_l;

   assign {a_exp, a_mant} = bus.a_in;
   assign {b_exp, b_mant} = bus.b_in;
   assign a_is_l = (a_exp > b_exp) || ((a_exp == b_exp) && (a_mant >= b_mant));

   always_comb begin
      l_exp  = b_exp;
      l_mant = b_mant;
      s_exp  = a_exp;
      s_mant = a_mant;
      if (a_is_l) begin
         l_exp  = a_exp;
         l_mant = a_mant;
         s_exp  = b_exp;
         s_mant = b_mant;
      end
   end

   assign shift = l_exp - s_exp;

   logic          s1_valid_q;
   logic [EW-1:0] s1_exp_q;
   logic [MW-1:0] s1_mant_l_q;
   logic [MW-1:0] s1_mant_s_q;
   logic [EW-1:0] s1_shift_q;

   // ---------------- Stage 2: align and add ----------------
   logic [TW-1:0] mant_l_ext, mant_s_ext, aligned, sum;

   assign mant_l_ext = {1'b0, s1_mant_l_q, 1'b0};
   assign mant_s_ext = {1'b0, s1_mant_s_q, 1'b0};

   always_comb begin
      aligned = mant_s_ext >> s1_shift_q;
      if (32'(s1_shift_q) >= MaxShift) begin
         aligned = '0;
      end
   end

   assign sum = mant_l_ext + aligned;

   logic          s2_valid_q;
   logic [EW-1:0] s2_exp_q;
   logic [TW-1:0] s2_sum_q;

   // ---------------- Stage 3: normalise, round, saturate ----------------
   logic [MW-1:0] norm_mant, fin_mant;
   logic [EW:0]   norm_exp, fin_exp;
   logic          guard;
   logic          fin_sat;
   logic [W-1:0]  fin_result;

   always_comb begin
      norm_mant = s2_sum_q[MW:1];
      guard     = s2_sum_q[0];
      norm_exp  = {1'b0, s2_exp_q};
      if (s2_sum_q[MW+1]) begin
         norm_mant = s2_sum_q[MW+1:2];
         guard     = s2_sum_q[1];
         norm_exp  = {1'b0, s2_exp_q} + ExpOne;
      end
   end

`ifdef FLOAT_ADD_ROUND_EN
   logic [MW:0] round_mant;

   // A rounding carry out of the mantissa renormalises once more before the saturation check.
   always_comb begin
      round_mant = {1'b0, norm_mant} + {{MW{1'b0}}, guard};
      fin_mant   = round_mant[MW-1:0];
      fin_exp    = norm_exp;
      if (round_mant[MW]) begin
         fin_mant = MantHalf;
         fin_exp  = norm_exp + ExpOne;
      end
   end
`else
   logic          unused_guard;
   logic [MW-1:0] unused_mant_half;

   assign unused_guard     = guard;
   assign unused_mant_half = MantHalf;
   assign fin_mant         = norm_mant;
   assign fin_exp          = norm_exp;
`endif

   assign fin_sat    = fin_exp > ExpMax;
   assign fin_result = fin_sat ? {W{1'b1}} : {fin_exp[EW-1:0], fin_mant};

   logic [W-1:0] result_q;
   logic         sat_q;

   assign bus.result = result_q;
   assign bus.sat    = sat_q;

   // ---------------- Pipeline registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_exp_q    <= '0;
         s1_mant_l_q <= '0;
         s1_mant_s_q <= '0;
         s1_shift_q  <= '0;
         s2_valid_q  <= 1'b0;
         s2_exp_q    <= '0;
         s2_sum_q    <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         sat_q       <= 1'b0;
      end else if (adv) begin
         s1_valid_q  <= bus.in_valid;
         s2_valid_q  <= s1_valid_q;
         out_valid_q <= s2_valid_q;
         if (bus.in_valid) begin
            s1_exp_q    <= l_exp;
            s1_mant_l_q <= l_mant;
            s1_mant_s_q <= s_mant;
            s1_shift_q  <= shift;
         end
         if (s1_valid_q) begin
            s2_exp_q <= s1_exp_q;
            s2_sum_q <= sum;
         end
         // Result only updates on real data so it holds across bubbles as well as stalls.
         if (s2_valid_q) begin
            result_q <= fin_result;
            sat_q    <= fin_sat;
         end
      end
   end

   result_held_while_stalled: assert property (
      @(posedge clk) disable iff (!rst_n)
      (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(result_q) && $stable(sat_q))
   );

   ready_tracks_adv: assert property (
      @(posedge clk) disable iff (!rst_n)
      !out_valid_q |-> bus.in_ready
   );

endmodule

// File: tb/tb_float_add_pipe.sv
// Directed self-checking bench for float_add_pipe (EW=3, MW=5); expectations are hand-computed.
module tb_float_add_pipe;
   localparam int unsigned EW = 3;
   localparam int unsigned MW = 5;

`ifdef FLOAT_ADD_ROUND_EN
   localparam logic [7:0] ExpR40 = 8'h41;
   localparam logic [7:0] ExpR5f = 8'h70;
   localparam logic       SatRff = 1'b1;
`else
   localparam logic [7:0] ExpR40 = 8'h40;
   localparam logic [7:0] ExpR5f = 8'h5F;
   localparam logic       SatRff = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   float_add_pipe_if #(.EW(EW), .MW(MW)) bus ();

   float_add_pipe #(.EW(EW), .MW(MW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One transaction with out_ready high; measures edges from accept to out_valid.
   task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_res, input logic exp_sat);
      int lat;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      bus.a_in      = a;
      bus.b_in      = b;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      check($sformatf("%s in_ready", tag), 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!bus.out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("%s latency", tag), 32'(lat), 32'd3);
      check($sformatf("%s result", tag), 32'(bus.result), 32'(exp_res));
      check($sformatf("%s sat", tag), 32'(bus.sat), 32'(exp_sat));
   endtask

   logic [7:0] bp_a   [6] = '{8'h45, 8'h30, 8'hFF, 8'hE0, 8'h5F, 8'hDF};
   logic [7:0] bp_b   [6] = '{8'h43, 8'h5C, 8'hE1, 8'h00, 8'h01, 8'hC1};
   logic [7:0] bp_exp [6] = '{8'h48, 8'h72, 8'hFF, 8'hE0, 8'h5F, 8'hF0};
   logic       bp_sat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   int         pops;
   int         stray;

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      pops          = 0;
      stray         = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a_in      = '0;
      bus.b_in      = '0;
      bus.out_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset result", 32'(bus.result), 32'd0);
      check("reset sat", 32'(bus.sat), 32'd0);
      check("reset in_ready", 32'(bus.in_ready), 32'd1);
      rst_n = 1'b1;

      run_one("basic", 8'h45, 8'h43, 8'h48, 1'b0);
      run_one("swap_carry", 8'h30, 8'h5C, 8'h72, 1'b0);
      run_one("swap_carry_rev", 8'h5C, 8'h30, 8'h72, 1'b0);
      run_one("exp_ovf", 8'hFF, 8'hE1, 8'hFF, 1'b1);
      run_one("max_no_ovf", 8'hE0, 8'h00, 8'hE0, 1'b0);
      run_one("zero", 8'h00, 8'h00, 8'h00, 1'b0);
      run_one("carry_to_max", 8'hDF, 8'hC1, 8'hF0, 1'b0);
      run_one("guard", 8'h40, 8'h21, ExpR40, 1'b0);
      run_one("far_shift", 8'h5F, 8'h01, 8'h5F, 1'b0);
      run_one("round_carry", 8'h5F, 8'h21, ExpR5f, 1'b0);
      run_one("round_sat", 8'hFF, 8'hC1, 8'hFF, SatRff);

      // Backpressure: out_ready low for 5 cycles while 6 pairs are offered back to back.
      @(posedge clk);
      #1;
      fork
         begin : producer
            bit acc;
            int tries;
            for (int i = 0; i < 6; i++) begin
               bus.a_in     = bp_a[i];
               bus.b_in     = bp_b[i];
               bus.in_valid = 1'b1;
               acc          = 1'b0;
               tries        = 0;
               while (!acc && tries < 30) begin
                  @(negedge clk);
                  acc = bus.in_ready;
                  @(posedge clk);
                  #1;
                  tries++;
               end
            end
            bus.in_valid = 1'b0;
         end
         begin : consumer
            for (int cyc = 0; cyc < 40 && pops < 6; cyc++) begin
               bus.out_ready = (cyc >= 5);
               @(negedge clk);
               if (cyc == 3 || cyc == 4) begin
                  check($sformatf("stall%0d in_ready", cyc), 32'(bus.in_ready), 32'd0);
                  check($sformatf("stall%0d out_valid", cyc), 32'(bus.out_valid), 32'd1);
                  check($sformatf("stall%0d result", cyc), 32'(bus.result), 32'(bp_exp[0]));
               end
               if (bus.out_valid && bus.out_ready) begin
                  check($sformatf("bp%0d result", pops), 32'(bus.result), 32'(bp_exp[pops]));
                  check($sformatf("bp%0d sat", pops), 32'(bus.sat), 32'(bp_sat[pops]));
                  pops++;
               end
               @(posedge clk);
               #1;
            end
         end
      join
      check("bp pop count", 32'(pops), 32'd6);
      @(negedge clk);
      check("bp drained", 32'(bus.out_valid), 32'd0);

      // Reset with two transactions in flight.
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      bus.a_in      = 8'h45;
      bus.b_in      = 8'h43;
      bus.in_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus.a_in = 8'h30;
      bus.b_in = 8'h5C;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async rst out_valid", 32'(bus.out_valid), 32'd0);
      check("async rst result", 32'(bus.result), 32'd0);
      check("async rst sat", 32'(bus.sat), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("post rst in_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.out_valid) stray++;
      end
      check("post rst no stale output", 32'(stray), 32'd0);
      run_one("post_rst", 8'h5F, 8'h01, 8'h5F, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
